// File: rtl/atomrvcore_memarb.sv
// Shares one single-ported memory bus between instruction fetch and load/store.
// Load/store has priority; a starvation counter guarantees that fetch makes progress.
module atomrvcore_memarb #(
  parameter int DATAWIDTH  = 32,
  parameter int ADDRWIDTH  = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 if_req_i,
  input  logic [ADDRWIDTH-1:0] if_addr_i,
  output logic                 if_gnt_o,
  output logic                 if_rvalid_o,
  output logic [DATAWIDTH-1:0] if_rdata_o,
  input  logic                 ls_req_i,
  input  logic                 ls_we_i,
  input  logic [3:0]           ls_be_i,
  input  logic [ADDRWIDTH-1:0] ls_addr_i,
  input  logic [DATAWIDTH-1:0] ls_wdata_i,
  output logic                 ls_gnt_o,
  output logic                 ls_rvalid_o,
  output logic [DATAWIDTH-1:0] ls_rdata_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [3:0]           mem_be_o,
  output logic [ADDRWIDTH-1:0] mem_addr_o,
  output logic [DATAWIDTH-1:0] mem_wdata_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [DATAWIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic       OWN_LS  = 1'b0;
  localparam logic       OWN_IF  = 1'b1;
  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 owner_q, owner_d;
  logic                 drop_q, drop_d;
  logic                 we_q, we_d;
  logic [3:0]           be_q, be_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d;
  logic                 if_gnt_q, if_gnt_d;
  logic                 ls_gnt_q, ls_gnt_d;
  logic                 if_rvalid_q, if_rvalid_d;
  logic                 ls_rvalid_q, ls_rvalid_d;
  logic [DATAWIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATAWIDTH-1:0] ls_rdata_q, ls_rdata_d;

  logic ls_win;
  logic if_win;
  logic if_kill;
  logic unused_addr_lsb;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 4'd1;
  endfunction

  // Fetch is word-aligned, so its low address bits are intentionally dropped.
  assign unused_addr_lsb = ^if_addr_i[1:0];

  assign ls_win  = ls_req_i && (!if_req_i || (cnt_q < CNT_MAX));
  assign if_win  = if_req_i && !ls_win;
  assign if_kill = drop_q || flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (ls_win || if_win) state_d = S_REQ;
      S_REQ:  if (mem_gnt_i)        state_d = S_WAIT;
      S_WAIT: if (mem_rvalid_i)     state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o   = (state_q == S_REQ);
    mem_we_o    = we_q;
    mem_be_o    = be_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    if_gnt_o    = if_gnt_q;
    ls_gnt_o    = ls_gnt_q;
    if_rvalid_o = if_rvalid_q;
    ls_rvalid_o = ls_rvalid_q;
    if_rdata_o  = if_rdata_q;
    ls_rdata_o  = ls_rdata_q;
  end

  always_comb begin
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_gnt_d    = 1'b0;
    ls_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (ls_win) begin
          owner_d  = OWN_LS;
          we_d     = ls_we_i;
          be_d     = ls_be_i;
          addr_d   = ls_addr_i;
          wdata_d  = ls_wdata_i;
          ls_gnt_d = 1'b1;
          // Only a win over a waiting fetch counts towards starvation.
          cnt_d    = if_req_i ? sat_inc(cnt_q) : 4'd0;
        end else if (if_win) begin
          owner_d  = OWN_IF;
          we_d     = 1'b0;
          be_d     = 4'hF;
          addr_d   = {if_addr_i[ADDRWIDTH-1:2], 2'b00};
          wdata_d  = '0;
          if_gnt_d = 1'b1;
          cnt_d    = 4'd0;
        end
      end
      S_REQ: begin
        if ((owner_q == OWN_IF) && flush_i) drop_d = 1'b1;
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          drop_d = 1'b0;
          if (owner_q == OWN_LS) begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = mem_rdata_i;
          end else if (!if_kill) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_i;
          end
        end else if ((owner_q == OWN_IF) && flush_i) begin
          drop_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q       <= 4'd0;
      owner_q     <= OWN_LS;
      drop_q      <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_gnt_q    <= if_gnt_d;
      ls_gnt_q    <= ls_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

endmodule

// File: doc/atomrvcore_memarb.md
Name: atomrvcore_memarb

Overview:
- Arbiter/sequencer that shares one single-ported unified memory bus between the instruction-fetch requester (IFU side) and the load/store requester.
- Fixed priority to load/store, with a starvation counter that guarantees fetch progress.
- One outstanding transaction at a time.
- Honours a fetch flush (branch/JAL/JALR redirect) by discarding the in-flight fetch response.

Parameters:
- DATAWIDTH, 32, data bus width.
- ADDRWIDTH, 32, address width.
- STARVE_MAX, 4, consecutive LS wins allowed while a fetch waits (range 1..15).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-low reset.
- flush_i  input  1  fetch redirect; kills the pending fetch response.
- if_req_i  input  1  fetch request; held until if_gnt_o.
- if_addr_i  input  ADDRWIDTH  fetch address.
- if_gnt_o  output  1  one-cycle fetch grant pulse.
- if_rvalid_o  output  1  one-cycle fetch data-valid pulse.
- if_rdata_o  output  DATAWIDTH  fetched instruction.
- ls_req_i  input  1  LS request; held until ls_gnt_o.
- ls_we_i  input  1  1=store, 0=load.
- ls_be_i  input  4  byte enables.
- ls_addr_i  input  ADDRWIDTH  LS address.
- ls_wdata_i  input  DATAWIDTH  store data.
- ls_gnt_o  output  1  one-cycle LS grant pulse.
- ls_rvalid_o  output  1  one-cycle LS completion pulse (load data or store ack).
- ls_rdata_o  output  DATAWIDTH  load data.
- mem_req_o  output  1  memory request.
- mem_we_o  output  1  memory write enable.
- mem_be_o  output  4  memory byte enables.
- mem_addr_o  output  ADDRWIDTH  memory address.
- mem_wdata_o  output  DATAWIDTH  memory write data.
- mem_gnt_i  input  1  memory accepted request this cycle.
- mem_rvalid_i  input  1  memory response valid.
- mem_rdata_i  input  DATAWIDTH  memory read data.

Behaviour:
- Reset: rst_i low asynchronously forces the following, regardless of state; an in-flight transaction is abandoned and no response is forwarded.
  - State IDLE, starvation counter 0, drop flag 0, owner 0.
  - All outputs 0.
- FSM states:
  - IDLE: evaluates requests each cycle.
  - REQ: mem_req_o held high with latched fields until mem_gnt_i.
  - WAIT: awaits mem_rvalid_i.
- IDLE arbitration at a rising edge:
  - If ls_req_i and (not if_req_i or cnt < STARVE_MAX): latch LS fields, owner=LS, go to REQ.
  - Else if if_req_i: latch fetch, owner=IF, go to REQ.
  - Else stay in IDLE.
- Grant pulse: the winner's gnt_o is high for exactly the one cycle after the latch edge. Requester fields are sampled only at the latch edge.
- Starvation counter:
  - On an LS win while if_req_i=1: cnt+1, saturating at STARVE_MAX.
  - On an IF win, or an LS win with if_req_i=0: cnt=0.
- Fetch field mapping: mem_we_o=0, mem_be_o=4'b1111, mem_addr_o={if_addr_i[ADDRWIDTH-1:2],2'b00}, mem_wdata_o=0.
- LS field mapping: fields passed unchanged.
- REQ:
  - mem_req_o=1 and fields stable while in REQ.
  - mem_gnt_i=1 -> WAIT, with mem_req_o low from the next cycle.
- WAIT:
  - mem_rvalid_i=1 -> IDLE.
  - Response is registered: owner rvalid_o pulses the next cycle with rdata_o=mem_rdata_i.
  - The same IDLE cycle may latch a new request, so back-to-back transactions start every 3 cycles minimum when mem_gnt_i/mem_rvalid_i are immediate.
- rdata_o holds its last value when rvalid_o=0.
- mem_rvalid_i outside WAIT is ignored.
- Flush:
  - flush_i=1 while owner=IF in REQ or WAIT sets the drop flag.
  - The memory handshake still completes; when it does, if_rvalid_o stays 0 and if_rdata_o is not updated.
  - The drop flag clears on return to IDLE.
  - flush_i in IDLE or with owner=LS has no effect.
  - flush_i in the same cycle as mem_rvalid_i drops that response.
- Simultaneous LS and IF requests with cnt=STARVE_MAX: IF wins.
- Requests arriving while not in IDLE wait; no queueing beyond the requester holding req.

Test Plan:
1. Single fetch.
   - Stimulus: if_req_i=1, if_addr_i=0x0000_0106, mem_gnt_i tied 1, mem_rvalid_i one cycle after grant with rdata 0x0000_0013.
   - Required: if_gnt_o pulses 1 cycle after req; mem_addr_o=0x0000_0104, mem_be_o=F, mem_we_o=0; if_rvalid_o pulses with 0x0000_0013; ls outputs stay 0.
2. Store with stalled memory.
   - Stimulus: ls_req_i, ls_we_i=1, be=4'b0011, addr=0x100, wdata=0xDEAD_BEEF; mem_gnt_i low 3 cycles.
   - Required: mem_req_o and fields stable for 4 cycles; ls_rvalid_o single pulse after mem_rvalid_i.
3. Contention and starvation, STARVE_MAX=4.
   - Stimulus: ls_req_i and if_req_i continuously high.
   - Required: grant order LS,LS,LS,LS,IF,LS,...; cnt returns to 0 after the IF grant.
4. Flush.
   - Stimulus: fetch granted; flush_i pulsed in WAIT.
   - Required: mem handshake completes, if_rvalid_o never asserts; next fetch to 0x200 returns normally.
   - Repeat with flush_i coincident with mem_rvalid_i: response dropped.
5. Reset mid-transaction.
   - Stimulus: rst_i low during REQ with mem_req_o=1.
   - Required: mem_req_o and all outputs 0 immediately, without waiting for a clock edge.
   - After release, IDLE with cnt=0; a late mem_rvalid_i is ignored.
6. Back-to-back LS loads.
   - Stimulus: immediate mem_gnt_i/mem_rvalid_i.
   - Required: grants every 3 cycles; each ls_rvalid_o carries the matching rdata in order.
